snn_core_tm: RTL and testbench

Time-multiplexed, leaky integrate-and-fire two-layer spiking core: input → hidden → output. It is the parametrised successor to the combinational-layer `snn_core`.
- Timesteps run on a start/done handshake. Each timestep updates one neuron per cycle through a single shared LIF datapath.
- Adds, per neuron: membrane leak, saturating membrane arithmetic, a refractory period, and a per-output spike counter.
- Sits between the spike encoder and the classifier readout.

---
 rtl/snn_pkg.sv | 33 +++
 rtl/lif_update.sv | 65 ++++++
 rtl/snn_core_tm.sv | 197 +++++++++++++++++++
 tb/tb_snn_core_tm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the time-multiplexed LIF spiking core.
// Holds the FSM state encoding, sum guard width and membrane saturation.
package snn_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HID,
        S_OUT,
        S_DONE
    } state_t;

    // Weighted sum width is W + clog2(PREV) + this guard bit.
    localparam int SUM_GUARD_BITS = 1;

    // Clamp a sign-extended value to the signed range of vw bits.
    function automatic logic signed [31:0] sat_v(
        input logic signed [31:0] x,
        input int                 vw
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (vw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (vw - 1));
        if (x > hi) begin
            sat_v = hi;
        end else if (x < lo) begin
            sat_v = lo;
        end else begin
            sat_v = x;
        end
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leaky integrate-and-fire update for a single neuron.
// Ports: i_v/i_r state, i_spikes/i_weights_row input, i_threshold; o_v_next/o_r_next/o_spike.
module lif_update
    import snn_pkg::*;
#(
    parameter int PREV_NEURONS = 16,
    parameter int W            = 8,
    parameter int V_WIDTH      = 16,
    parameter int LEAK_SHIFT   = 4,
    parameter int REFRACT      = 2,
    parameter int RW           = 2
) (
    input  logic signed [V_WIDTH-1:0] i_v,
    input  logic        [RW-1:0]      i_r,
    input  logic                      i_spikes      [PREV_NEURONS],
    input  logic signed [W-1:0]       i_weights_row [PREV_NEURONS],
    input  logic signed [V_WIDTH-1:0] i_threshold,
    output logic signed [V_WIDTH-1:0] o_v_next,
    output logic        [RW-1:0]      o_r_next,
    output logic                      o_spike
);

    localparam int SUM_W = W + $clog2(PREV_NEURONS) + SUM_GUARD_BITS;
    localparam int ACC_W = V_WIDTH + 2;

    logic signed [SUM_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_v_ext;
    logic signed [ACC_W-1:0]   w_sum_ext;
    logic signed [ACC_W-1:0]   w_acc;
    logic signed [31:0]        w_acc32;
    logic signed [31:0]        w_sat32;
    logic signed [V_WIDTH-1:0] w_v_sat;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < PREV_NEURONS; i++) begin
            if (i_spikes[i]) begin
                w_sum = w_sum + SUM_W'(i_weights_row[i]);
            end
        end
    end

    // Two guard bits keep v - leak + sum exact before clamping.
    assign w_v_ext   = ACC_W'(i_v);
    assign w_sum_ext = ACC_W'(w_sum);
    assign w_acc     = w_v_ext - (w_v_ext >>> LEAK_SHIFT) + w_sum_ext;
    assign w_acc32   = 32'(w_acc);
    assign w_sat32   = sat_v(w_acc32, V_WIDTH);
    assign w_v_sat   = w_sat32[V_WIDTH-1:0];

    always_comb begin
        o_v_next = w_v_sat;
        o_r_next = i_r;
        o_spike  = 1'b0;
        if (i_r != '0) begin
            o_v_next = '0;
            o_r_next = i_r - 1'b1;
        end else if (w_v_sat >= i_threshold) begin
            o_spike  = 1'b1;
            o_v_next = '0;
            o_r_next = RW'(REFRACT);
        end
    end

endmodule

// File: rtl/snn_core_tm.sv
// Time-multiplexed two-layer LIF core: one neuron per cycle through one datapath.
// Ports: start/spikes_in/weights/v_threshold/clear_counts in; busy/done/spikes_out/spike_count out.
module snn_core_tm
    import snn_pkg::*;
#(
    parameter int INPUT_NEURONS  = 8,
    parameter int HIDDEN_NEURONS = 16,
    parameter int OUTPUT_NEURONS = 4,
    parameter int W              = 8,
    parameter int V_WIDTH        = 16,
    parameter int LEAK_SHIFT     = 4,
    parameter int REFRACT        = 2,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      spikes_in [INPUT_NEURONS],
    input  logic signed [W-1:0]       weights_input_to_hidden  [HIDDEN_NEURONS][INPUT_NEURONS],
    input  logic signed [W-1:0]       weights_hidden_to_output [OUTPUT_NEURONS][HIDDEN_NEURONS],
    input  logic signed [V_WIDTH-1:0] v_threshold,
    input  logic                      clear_counts,
    output logic                      busy,
    output logic                      done,
    output logic                      spikes_out  [OUTPUT_NEURONS],
    output logic [CNT_WIDTH-1:0]      spike_count [OUTPUT_NEURONS]
);

    localparam int PREV_N = (INPUT_NEURONS > HIDDEN_NEURONS) ? INPUT_NEURONS : HIDDEN_NEURONS;
    localparam int RW     = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
    localparam int HW     = (HIDDEN_NEURONS < 2) ? 1 : $clog2(HIDDEN_NEURONS);
    localparam int OW     = (OUTPUT_NEURONS < 2) ? 1 : $clog2(OUTPUT_NEURONS);
    localparam int IW     = (HW > OW) ? HW : OW;
    localparam logic [IW-1:0] LAST_H = IW'(HIDDEN_NEURONS - 1);
    localparam logic [IW-1:0] LAST_O = IW'(OUTPUT_NEURONS - 1);

    state_t r_state;
    state_t w_state_next;

    logic [IW-1:0] r_idx;
    logic [HW-1:0] w_idx_h;
    logic [OW-1:0] w_idx_o;
    logic          w_last_h;
    logic          w_last_o;

    logic                      r_spk_in  [INPUT_NEURONS];
    logic                      r_spk_hid [HIDDEN_NEURONS];
    logic signed [V_WIDTH-1:0] r_v_hid   [HIDDEN_NEURONS];
    logic        [RW-1:0]      r_r_hid   [HIDDEN_NEURONS];
    logic signed [V_WIDTH-1:0] r_v_out   [OUTPUT_NEURONS];
    logic        [RW-1:0]      r_r_out   [OUTPUT_NEURONS];
    logic                      r_spk_acc [OUTPUT_NEURONS];

    logic                      w_spk_sel [PREV_N];
    logic signed [W-1:0]       w_row_sel [PREV_N];
    logic signed [V_WIDTH-1:0] w_v_sel;
    logic        [RW-1:0]      w_r_sel;
    logic signed [V_WIDTH-1:0] w_v_next;
    logic        [RW-1:0]      w_r_next;
    logic                      w_spike;
    logic                      w_spk_fin [OUTPUT_NEURONS];

    assign w_idx_h  = r_idx[HW-1:0];
    assign w_idx_o  = r_idx[OW-1:0];
    assign w_last_h = (r_idx == LAST_H);
    assign w_last_o = (r_idx == LAST_O);

    // Layer mux in front of the shared datapath; unused lanes are zero.
    always_comb begin
        for (int i = 0; i < PREV_N; i++) begin
            w_spk_sel[i] = 1'b0;
            w_row_sel[i] = '0;
        end
        w_v_sel = '0;
        w_r_sel = '0;
        if (r_state == S_OUT) begin
            for (int i = 0; i < HIDDEN_NEURONS; i++) begin
                w_spk_sel[i] = r_spk_hid[i];
                w_row_sel[i] = weights_hidden_to_output[w_idx_o][i];
            end
            w_v_sel = r_v_out[w_idx_o];
            w_r_sel = r_r_out[w_idx_o];
        end else begin
            for (int i = 0; i < INPUT_NEURONS; i++) begin
                w_spk_sel[i] = r_spk_in[i];
                w_row_sel[i] = weights_input_to_hidden[w_idx_h][i];
            end
            w_v_sel = r_v_hid[w_idx_h];
            w_r_sel = r_r_hid[w_idx_h];
        end
    end

    lif_update #(
        .PREV_NEURONS (PREV_N),
        .W            (W),
        .V_WIDTH      (V_WIDTH),
        .LEAK_SHIFT   (LEAK_SHIFT),
        .REFRACT      (REFRACT),
        .RW           (RW)
    ) u_lif (
        .i_v           (w_v_sel),
        .i_r           (w_r_sel),
        .i_spikes      (w_spk_sel),
        .i_weights_row (w_row_sel),
        .i_threshold   (v_threshold),
        .o_v_next      (w_v_next),
        .o_r_next      (w_r_next),
        .o_spike       (w_spike)
    );

    // Output spikes of this timestep, including the neuron being updated now.
    always_comb begin
        for (int k = 0; k < OUTPUT_NEURONS; k++) begin
            w_spk_fin[k] = r_spk_acc[k];
            if (w_idx_o == OW'(k)) begin
                w_spk_fin[k] = w_spike;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_state_next = S_HID;
            S_HID:  if (w_last_h) w_state_next = S_OUT;
            S_OUT:  if (w_last_o) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < INPUT_NEURONS; i++) begin
                r_spk_in[i] <= 1'b0;
            end
            for (int j = 0; j < HIDDEN_NEURONS; j++) begin
                r_spk_hid[j] <= 1'b0;
                r_v_hid[j]   <= '0;
                r_r_hid[j]   <= '0;
            end
            for (int k = 0; k < OUTPUT_NEURONS; k++) begin
                r_v_out[k]     <= '0;
                r_r_out[k]     <= '0;
                r_spk_acc[k]   <= 1'b0;
                spikes_out[k]  <= 1'b0;
                spike_count[k] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            busy    <= (w_state_next != S_IDLE);
            done    <= (w_state_next == S_DONE);
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < INPUT_NEURONS; i++) begin
                            r_spk_in[i] <= spikes_in[i];
                        end
                        r_idx <= '0;
                    end
                end
                S_HID: begin
                    r_v_hid[w_idx_h]   <= w_v_next;
                    r_r_hid[w_idx_h]   <= w_r_next;
                    r_spk_hid[w_idx_h] <= w_spike;
                    r_idx <= w_last_h ? '0 : r_idx + 1'b1;
                end
                S_OUT: begin
                    r_v_out[w_idx_o]   <= w_v_next;
                    r_r_out[w_idx_o]   <= w_r_next;
                    r_spk_acc[w_idx_o] <= w_spike;
                    r_idx <= r_idx + 1'b1;
                    if (w_last_o) begin
                        for (int k = 0; k < OUTPUT_NEURONS; k++) begin
                            spikes_out[k] <= w_spk_fin[k];
                        end
                    end
                end
                default: ;
            endcase
            // Clear has priority over a same-cycle increment.
            for (int k = 0; k < OUTPUT_NEURONS; k++) begin
                if (clear_counts) begin
                    spike_count[k] <= '0;
                end else if (r_state == S_OUT && w_last_o && w_spk_fin[k]
                             && spike_count[k] != '1) begin
                    spike_count[k] <= spike_count[k] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snn_core_tm.sv
// Directed bench for snn_core_tm: firing/refractory, leak, saturation, counters, handshake, reset.
// Instance a uses defaults; instance b uses V_WIDTH=11, REFRACT=0, CNT_WIDTH=2.
module tb_snn_core_tm;

    localparam int I = 8;
    localparam int H = 16;
    localparam int O = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic clear_counts;
    logic spikes_in [I];
    logic signed [7:0]  w_ih [H][I];
    logic signed [7:0]  w_ho [O][H];
    logic signed [15:0] th_a;
    logic signed [10:0] th_b;

    logic       busy_a, done_a, busy_b, done_b;
    logic       so_a [O];
    logic       so_b [O];
    logic [7:0] cnt_a [O];
    logic [1:0] cnt_b [O];

    int n_checks = 0;
    int n_errors = 0;

    snn_core_tm dut_a (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .spikes_in                (spikes_in),
        .weights_input_to_hidden  (w_ih),
        .weights_hidden_to_output (w_ho),
        .v_threshold              (th_a),
        .clear_counts             (clear_counts),
        .busy                     (busy_a),
        .done                     (done_a),
        .spikes_out               (so_a),
        .spike_count              (cnt_a)
    );

    snn_core_tm #(
        .V_WIDTH   (11),
        .REFRACT   (0),
        .CNT_WIDTH (2)
    ) dut_b (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .spikes_in                (spikes_in),
        .weights_input_to_hidden  (w_ih),
        .weights_hidden_to_output (w_ho),
        .v_threshold              (th_b),
        .clear_counts             (clear_counts),
        .busy                     (busy_b),
        .done                     (done_b),
        .spikes_out               (so_b),
        .spike_count              (cnt_b)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pk(input logic s [O]);
        pk = '0;
        for (int k = 0; k < O; k++) pk[k] = s[k];
    endfunction

    function automatic logic [31:0] pca(input logic [7:0] c [O]);
        pca = {c[3], c[2], c[1], c[0]};
    endfunction

    function automatic logic [7:0] pcb(input logic [1:0] c [O]);
        pcb = {c[3], c[2], c[1], c[0]};
    endfunction

    task automatic set_w(input int vih, input int vho);
        for (int j = 0; j < H; j++)
            for (int i = 0; i < I; i++) w_ih[j][i] = 8'(vih);
        for (int k = 0; k < O; k++)
            for (int j = 0; j < H; j++) w_ho[k][j] = 8'(vho);
    endtask

    task automatic set_in(input logic [7:0] m);
        for (int i = 0; i < I; i++) spikes_in[i] = m[i];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one timestep from IDLE; returns at the negedge of the done cycle.
    task automatic run_ts(input bit poke);
        int n;
        bit got;
        @(negedge clk);
        check("idle_busy", {busy_a, busy_b}, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        got = done_a;
        while (!got && n < 60) begin
            if (poke && n == 4) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n++;
            got = done_a;
        end
        check("latency", got ? n : -1, H + O + 1);
    endtask

    initial begin
        logic [6:0] fire;
        int lv [3];
        logic [1:0] e;
        bit seen;

        rst = 1'b1;
        start = 1'b0;
        clear_counts = 1'b0;
        th_a = 16'sd64;
        th_b = 11'sd64;
        set_w(0, 0);
        set_in(8'h00);
        repeat (2) @(negedge clk);
        check("rst_busy", {busy_a, busy_b}, 0);
        check("rst_done", {done_a, done_b}, 0);
        check("rst_so", {pk(so_a), pk(so_b)}, 0);
        check("rst_cnt_a", pca(cnt_a), 0);
        check("rst_cnt_b", pcb(cnt_b), 0);
        rst = 1'b0;

        // Firing with refractory: spikes at timesteps 1, 4, 7.
        set_w(10, 10);
        set_in(8'hFF);
        fire = 7'b1001001;
        for (int t = 0; t < 7; t++) begin
            run_ts(t == 0);
            check($sformatf("fire_ts%0d", t + 1), pk(so_a), fire[t] ? 4'hF : 4'h0);
        end
        check("fire_cnt", pca(cnt_a), 32'h03030303);

        // Leak: hidden 0 integrates 20, 39, 57 and fires at timestep 4.
        do_reset();
        set_w(0, 0);
        w_ih[0][0] = 8'sd20;
        for (int k = 0; k < O; k++) w_ho[k][0] = 8'sd100;
        set_in(8'h01);
        lv = '{20, 39, 57};
        for (int t = 0; t < 3; t++) begin
            run_ts(0);
            check($sformatf("leak_v%0d", t + 1), dut_a.r_v_hid[0], lv[t]);
            check($sformatf("leak_so%0d", t + 1), pk(so_a), 0);
        end
        run_ts(0);
        check("leak_fire", pk(so_a), 4'hF);
        check("leak_v4", dut_a.r_v_hid[0], 0);

        // Saturation on the 11-bit membrane; the 16-bit one stays exact.
        do_reset();
        set_w(-128, 0);
        set_in(8'hFF);
        run_ts(0);
        check("sat_v1", dut_b.r_v_hid[0], -1024);
        check("sat_v1_h15", dut_b.r_v_hid[15], -1024);
        run_ts(0);
        check("sat_v2", dut_b.r_v_hid[0], -1024);
        check("wide_v2", dut_a.r_v_hid[0], -1984);

        // Saturating 2-bit counter with an always-firing configuration.
        do_reset();
        set_w(10, 10);
        set_in(8'hFF);
        for (int t = 0; t < 4; t++) begin
            run_ts(0);
            e = (t < 3) ? 2'(t + 1) : 2'd3;
            check($sformatf("cnt_ts%0d", t + 1), pcb(cnt_b), {e, e, e, e});
            check($sformatf("cnt_so%0d", t + 1), pk(so_b), 4'hF);
        end
        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        check("clr_done_b", pcb(cnt_b), 0);
        check("clr_done_a", pca(cnt_a), 0);
        clear_counts = 1'b1;
        run_ts(0);
        check("clr_wins", pcb(cnt_b), 0);
        clear_counts = 1'b0;
        run_ts(0);
        check("cnt_after_clr", pcb(cnt_b), 8'h55);

        // Reset during OUT: outputs zero next cycle and no done follows.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
        check("busy_in_out", busy_b, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstout_busy", {busy_a, busy_b}, 0);
        check("rstout_done", {done_a, done_b}, 0);
        check("rstout_so", pk(so_b), 0);
        check("rstout_cnt", pcb(cnt_b), 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_a || done_b) seen = 1'b1;
        end
        check("rstout_nodone", seen, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
